// File: rtl/pc_fetch_pkg.sv
// Shared types and helpers for the PC / fetch-control stage.
package pc_fetch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      HALT  = 2'd2,
      FAULT = 2'd3
   } fetch_state_t;

   typedef logic [15:0] addr_t;
   typedef logic [31:0] instr_t;

   localparam addr_t PC_STEP = 16'd4;

   // A fetch target is usable only if it is word aligned and inside the memory.
   function automatic logic target_ok(input addr_t addr, input int unsigned words);
      logic [31:0] limit;
      limit     = words * 32'd4;
      target_ok = (addr[1:0] == 2'b00) && ({16'h0000, addr} < limit);
   endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC priority mux (hold > jump > branch > sequential) with target check.
module next_pc_sel
   import pc_fetch_pkg::*;
#(
   parameter int unsigned IMEM_WORDS = 1024
) (
   input  addr_t pc,
   input  logic  stall,
   input  logic  jump,
   input  addr_t jump_target,
   input  logic  branch_taken,
   input  addr_t branch_target,
   output addr_t next_pc,
   output logic  bad_target
);

   // Pick the candidate next PC; sequential step wraps naturally at 16 bits.
   always_comb begin
      next_pc = pc + PC_STEP;
      if (stall) begin
         next_pc = pc;
      end else if (jump) begin
         next_pc = jump_target;
      end else if (branch_taken) begin
         next_pc = branch_target;
      end else begin
         next_pc = pc + PC_STEP;
      end
   end

   // Every candidate, including the sequential one, is range/alignment checked.
   always_comb begin
      bad_target = !target_ok(next_pc, IMEM_WORDS);
   end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter, fetch FSM, halt/fault detection and retired-fetch counter.
module pc_fetch_unit
   import pc_fetch_pkg::*;
#(
   parameter addr_t       RESET_PC   = 16'h0000,
   parameter int unsigned IMEM_WORDS = 1024,
   parameter instr_t      HALT_INSTR = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [15:0] branch_target,
   input  logic        jump,
   input  logic [15:0] jump_target,
   output logic [15:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [15:0] instr_pc,
   output logic        instr_valid,
   output logic        halted,
   output logic        fault,
   output logic [15:0] fault_addr,
   output logic [31:0] retired
);

   fetch_state_t state_r;
   addr_t        pc_r;
   addr_t        fault_addr_r;
   logic [31:0]  retired_r;

   logic  in_run_s;
   logic  accept_s;
   logic  is_halt_s;
   logic  sel_stall_s;
   logic  sel_jump_s;
   logic  sel_branch_s;
   addr_t next_pc_s;
   logic  bad_target_s;

   // Redirect controls only matter in RUN; in HALT the mux yields pc+4 for resume.
   always_comb begin
      in_run_s     = (state_r == RUN);
      accept_s     = in_run_s && !stall;
      is_halt_s    = (imem_rdata == HALT_INSTR);
      sel_stall_s  = in_run_s && stall;
      sel_jump_s   = in_run_s && jump;
      sel_branch_s = in_run_s && branch_taken;
   end

   next_pc_sel #(
      .IMEM_WORDS (IMEM_WORDS)
   ) u_next_pc_sel (
      .pc            (pc_r),
      .stall         (sel_stall_s),
      .jump          (sel_jump_s),
      .jump_target   (jump_target),
      .branch_taken  (sel_branch_s),
      .branch_target (branch_target),
      .next_pc       (next_pc_s),
      .bad_target    (bad_target_s)
   );

   // Fetch FSM with PC, fault address and retired counter updates.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         pc_r         <= RESET_PC;
         fault_addr_r <= 16'h0000;
         retired_r    <= 32'd0;
      end else begin
         case (state_r)
            IDLE: begin
               if (start) begin
                  state_r <= RUN;
               end else begin
                  state_r <= IDLE;
               end
            end
            RUN: begin
               if (accept_s) begin
                  retired_r <= retired_r + 32'd1;
                  if (is_halt_s) begin
                     // PC stays on the halt word; redirects this cycle are dropped.
                     state_r <= HALT;
                  end else if (bad_target_s) begin
                     state_r      <= FAULT;
                     fault_addr_r <= next_pc_s;
                  end else begin
                     pc_r <= next_pc_s;
                  end
               end else begin
                  state_r <= RUN;
               end
            end
            HALT: begin
               if (start) begin
                  if (bad_target_s) begin
                     state_r      <= FAULT;
                     fault_addr_r <= next_pc_s;
                  end else begin
                     state_r <= RUN;
                     pc_r    <= next_pc_s;
                  end
               end else begin
                  state_r <= HALT;
               end
            end
            FAULT: begin
               state_r <= FAULT;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   // Outputs are a direct view of registered state plus the memory's data path.
   always_comb begin
      imem_addr   = pc_r;
      instr_pc    = pc_r;
      instr_valid = (state_r == RUN);
      halted      = (state_r == HALT);
      fault       = (state_r == FAULT);
      fault_addr  = fault_addr_r;
      retired     = retired_r;
      if (state_r == RUN) begin
         instr = imem_rdata;
      end else begin
         instr = 32'h0000_0000;
      end
   end

endmodule
